// File: rtl/axi_reg_pkg.sv
// axi_reg_pkg: shared types and constants for the AXI register block read and write paths.
package axi_reg_pkg;
    localparam int DATA_W = 32;
    localparam int STRB_W = 4;
    typedef enum logic [1:0] {OKAY = 2'b00, SLVERR = 2'b10} resp_t;
    typedef enum logic [1:0] {IDLE, READ, RESP} rd_state_t;
endpackage

// File: rtl/lane_masker.sv
// lane_masker: byte-lane mask from a byte offset; lanes below the offset are cleared.
module lane_masker
    import axi_reg_pkg::*;
(
    input  logic [1:0]        i_offset,
    output logic [STRB_W-1:0] o_mask
);
    assign o_mask = {STRB_W{1'b1}} << i_offset;
endmodule

// File: rtl/axi_reg_reader.sv
// axi_reg_reader: AXI4-Lite read responder; one outstanding read, register file
// sampled once in READ and the masked response held until R is accepted.
module axi_reg_reader
    import axi_reg_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int NUM_REGS  = 16,
    parameter int REG_IDX_W = $clog2(NUM_REGS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ADDR_W-1:0]    araddr,
    input  logic                 arvalid,
    output logic                 arready,
    output logic [DATA_W-1:0]    rdata,
    output logic [1:0]           rresp,
    output logic                 rvalid,
    input  logic                 rready,
    output logic                 reg_re,
    output logic [REG_IDX_W-1:0] reg_raddr,
    input  logic [DATA_W-1:0]    reg_rdata
);
    rd_state_t           r_state;
    rd_state_t           w_next;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_rdata;
    resp_t               r_rresp;
    logic [ADDR_W-3:0]   w_idx;
    logic                w_err;
    logic [STRB_W-1:0]   w_strb;
    logic [DATA_W-1:0]   w_lane_mask;

    assign w_idx = r_addr[ADDR_W-1:2];
    // full-width compare so aliased high indices still report SLVERR
    assign w_err = 32'(w_idx) >= 32'(NUM_REGS);

    lane_masker u_lane_masker (
        .i_offset(r_addr[1:0]),
        .o_mask  (w_strb)
    );

    for (genvar b = 0; b < STRB_W; b++) begin : g_lane
        assign w_lane_mask[8*b +: 8] = {8{w_strb[b]}};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = (r_state == IDLE) ? (arvalid ? READ : IDLE) :
                 (r_state == READ) ? RESP :
                 (rready ? IDLE : RESP);
    end

    always_comb begin
        arready   = rst_n && (r_state == IDLE);
        rvalid    = (r_state == RESP);
        reg_re    = (r_state == READ) && !w_err;
        reg_raddr = reg_re ? w_idx[REG_IDX_W-1:0] : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr  <= '0;
            r_rdata <= '0;
            r_rresp <= OKAY;
        end else begin
            if (r_state == IDLE && arvalid) r_addr <= araddr;
            if (r_state == READ) begin
                r_rdata <= w_err ? '0 : (reg_rdata & w_lane_mask);
                r_rresp <= w_err ? SLVERR : OKAY;
            end
        end
    end

    assign rdata = r_rdata;
    assign rresp = r_rresp;
endmodule

// File: tb/tb_axi_reg_reader.sv
// tb_axi_reg_reader: directed vector table plus hold, back-to-back and async-reset sequences.
module tb_axi_reg_reader;
    logic        clk, rst_n, arvalid, arready, rvalid, rready, reg_re;
    logic [7:0]  araddr;
    logic [31:0] rdata, reg_rdata;
    logic [1:0]  rresp;
    logic [3:0]  reg_raddr;
    logic [31:0] regs [16];
    int          passed = 0, total = 0, re_cnt = 0, cyc = 0, viol = 0;
    int          hs_q [$];

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
        logic        exp_re;
        logic [3:0]  exp_raddr;
    } vec_t;
    vec_t vecs [10];

    axi_reg_reader dut (
        .clk(clk), .rst_n(rst_n), .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .reg_re(reg_re), .reg_raddr(reg_raddr), .reg_rdata(reg_rdata)
    );

    assign reg_rdata = regs[reg_raddr];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (arvalid && arready) hs_q.push_back(cyc);
        if (reg_re) re_cnt++;
        cyc++;
    end

    always @(negedge clk) if (arready && rvalid) viol++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic do_read(input vec_t v, input int n);
        int re0;
        araddr = v.addr; arvalid = 1; rready = 1;
        check($sformatf("v%0d arready_idle", n), 32'(arready), 32'd1);
        @(posedge clk); #1;
        arvalid = 0;
        re0 = re_cnt;
        check($sformatf("v%0d reg_re", n), 32'(reg_re), 32'(v.exp_re));
        check($sformatf("v%0d reg_raddr", n), 32'(reg_raddr), 32'(v.exp_raddr));
        check($sformatf("v%0d rvalid_read", n), 32'(rvalid), 32'd0);
        check($sformatf("v%0d arready_read", n), 32'(arready), 32'd0);
        @(posedge clk); #1;
        check($sformatf("v%0d rvalid", n), 32'(rvalid), 32'd1);
        check($sformatf("v%0d rdata", n), rdata, v.exp_data);
        check($sformatf("v%0d rresp", n), 32'(rresp), 32'(v.exp_resp));
        check($sformatf("v%0d re_pulses", n), 32'(re_cnt - re0), 32'(v.exp_re));
        @(posedge clk); #1;
        check($sformatf("v%0d rvalid_done", n), 32'(rvalid), 32'd0);
        check($sformatf("v%0d arready_done", n), 32'(arready), 32'd1);
    endtask

    initial begin
        logic [7:0]  b2b_addr [3];
        logic [31:0] b2b_exp  [3];
        int          h0;
        clk = 0; rst_n = 0; araddr = '0; arvalid = 0; rready = 0;
        for (int i = 0; i < 16; i++) regs[i] = '0;
        regs[0] = 32'h11223344; regs[3] = 32'hDEADBEEF;
        regs[14] = 32'h12345678; regs[15] = 32'hCAFEF00D;
        vecs[0] = '{8'h0C, 32'hDEADBEEF, 2'b00, 1'b1, 4'd3};
        vecs[1] = '{8'h0E, 32'hDEAD0000, 2'b00, 1'b1, 4'd3};
        vecs[2] = '{8'h0F, 32'hDE000000, 2'b00, 1'b1, 4'd3};
        vecs[3] = '{8'h0D, 32'hDEADBE00, 2'b00, 1'b1, 4'd3};
        vecs[4] = '{8'h40, 32'h00000000, 2'b10, 1'b0, 4'd0};
        vecs[5] = '{8'h00, 32'h11223344, 2'b00, 1'b1, 4'd0};
        vecs[6] = '{8'h3F, 32'hCA000000, 2'b00, 1'b1, 4'd15};
        vecs[7] = '{8'hFC, 32'h00000000, 2'b10, 1'b0, 4'd0};
        vecs[8] = '{8'h41, 32'h00000000, 2'b10, 1'b0, 4'd0};
        vecs[9] = '{8'h3A, 32'h12340000, 2'b00, 1'b1, 4'd14};
        b2b_addr = '{8'h0C, 8'h0E, 8'h3F};
        b2b_exp  = '{32'hDEADBEEF, 32'hDEAD0000, 32'hCA000000};

        #12;
        check("rst arready", 32'(arready), 32'd0);
        check("rst rvalid", 32'(rvalid), 32'd0);
        check("rst rdata", rdata, 32'd0);
        check("rst rresp", 32'(rresp), 32'd0);
        check("rst reg_re", 32'(reg_re), 32'd0);
        check("rst reg_raddr", 32'(reg_raddr), 32'd0);
        @(posedge clk); #1; rst_n = 1;
        @(posedge clk); #1;
        check("post_rst arready", 32'(arready), 32'd1);

        for (int i = 0; i < 10; i++) do_read(vecs[i], i);

        // backpressure: response held, register changes ignored, second AR waits
        araddr = 8'h0C; arvalid = 1; rready = 0;
        h0 = hs_q.size();
        @(posedge clk); #1; araddr = 8'h00;
        @(posedge clk); #1; regs[3] = 32'h0;
        for (int i = 0; i < 10; i++) begin
            check($sformatf("hold%0d rvalid", i), 32'(rvalid), 32'd1);
            check($sformatf("hold%0d rdata", i), rdata, 32'hDEADBEEF);
            check($sformatf("hold%0d rresp", i), 32'(rresp), 32'd0);
            check($sformatf("hold%0d arready", i), 32'(arready), 32'd0);
            @(posedge clk); #1;
        end
        check("hold hs_count", 32'(hs_q.size() - h0), 32'd1);
        rready = 1;
        @(posedge clk); #1;
        check("hold rvalid_after_r", 32'(rvalid), 32'd0);
        check("hold arready_after_r", 32'(arready), 32'd1);
        check("hold hs_before_idle", 32'(hs_q.size() - h0), 32'd1);
        @(posedge clk); #1; arvalid = 0;
        check("hold second_hs", 32'(hs_q.size() - h0), 32'd2);
        if (hs_q.size() - h0 == 2) check("hold hs_gap", 32'(hs_q[h0+1] - hs_q[h0]), 32'd13);
        check("hold second reg_re", 32'(reg_re), 32'd1);
        check("hold second reg_raddr", 32'(reg_raddr), 32'd0);
        @(posedge clk); #1;
        check("hold second rdata", rdata, 32'h11223344);
        @(posedge clk); #1;
        regs[3] = 32'hDEADBEEF;

        // back-to-back with arvalid and rready held high
        h0 = hs_q.size();
        arvalid = 1; rready = 1;
        for (int i = 0; i < 3; i++) begin
            araddr = b2b_addr[i];
            @(posedge clk); #1;
            if (i == 2) arvalid = 0;
            @(posedge clk); #1;
            check($sformatf("b2b%0d rdata", i), rdata, b2b_exp[i]);
            check($sformatf("b2b%0d rresp", i), 32'(rresp), 32'd0);
            @(posedge clk); #1;
        end
        check("b2b hs_count", 32'(hs_q.size() - h0), 32'd3);
        if (hs_q.size() - h0 >= 3) begin
            check("b2b gap0", 32'(hs_q[h0+1] - hs_q[h0]), 32'd3);
            check("b2b gap1", 32'(hs_q[h0+2] - hs_q[h0+1]), 32'd3);
        end

        // async reset while a response is pending
        araddr = 8'h0C; arvalid = 1; rready = 0;
        @(posedge clk); #1; arvalid = 0;
        @(posedge clk); #1;
        check("arst rvalid_before", 32'(rvalid), 32'd1);
        #1 rst_n = 0;
        #1;
        check("arst rvalid", 32'(rvalid), 32'd0);
        check("arst arready", 32'(arready), 32'd0);
        check("arst reg_re", 32'(reg_re), 32'd0);
        check("arst rdata", rdata, 32'd0);
        #1 rst_n = 1; rready = 1;
        @(posedge clk); #1;
        check("arst arready_after", 32'(arready), 32'd1);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("arst stale%0d", i), 32'(rvalid), 32'd0);
            @(posedge clk); #1;
        end
        check("never arready_and_rvalid", 32'(viol), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
